// File: rtl/ahb_lite_regfile_slave.sv
// rtl/ahb_lite_regfile_slave.sv - AHB-Lite slave with 16 x 32-bit byte-writable registers.
// Define AHB_REGFILE_WAIT_STATE_EN to insert one wait cycle into every legal data phase.
module ahb_lite_regfile_slave (
  input  logic        HCLK,
  input  logic        HRESETIN,
  input  logic        HSELX,
  input  logic        HREADY,
  input  logic        HWRITE,
  input  logic [1:0]  HTRANS,
  input  logic [1:0]  HSIZE,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_t;

`ifdef AHB_REGFILE_WAIT_STATE_EN
  localparam state_t LEGAL_STATE = ST_WAIT;
`else
  localparam state_t LEGAL_STATE = ST_DATA;
`endif

  state_t      state;
  logic [31:0] regs [16];
  logic        wr_q;
  logic [1:0]  size_q;
  logic [5:0]  addr_q;

  logic        accept;
  logic        illegal;
  logic        commit;
  logic [3:0]  lane_en;
  logic [3:0]  widx;
  logic [3:0]  ridx;
  logic [31:0] merged;
  logic        unused_ok;

  assign unused_ok = ^{HADDR[31:6], HTRANS[0]};

  always_comb begin
    accept = HSELX && HREADY && HTRANS[1];
    case (HSIZE)
      2'b00:   illegal = 1'b0;
      2'b01:   illegal = HADDR[0];
      2'b10:   illegal = |HADDR[1:0];
      default: illegal = 1'b1;
    endcase
    widx   = addr_q[5:2];
    ridx   = HADDR[5:2];
    commit = (state == ST_DATA) && wr_q;
    case (size_q)
      2'b00:   lane_en = 4'b0001 << addr_q[1:0];
      2'b01:   lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
      default: lane_en = 4'b1111;
    endcase
    // Pending write merged into the old value; also used to bypass a read of the same register.
    merged = regs[widx];
    for (int b = 0; b < 4; b++) begin
      if (lane_en[b]) merged[8*b +: 8] = HWDATA[8*b +: 8];
    end
  end

  always_ff @(posedge HCLK or negedge HRESETIN) begin
    if (!HRESETIN) begin
      state     <= ST_IDLE;
      wr_q      <= 1'b0;
      size_q    <= 2'b00;
      addr_q    <= 6'd0;
      HRDATA    <= 32'd0;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      for (int i = 0; i < 16; i++) regs[i] <= 32'd0;
    end else begin
      if (commit) regs[widx] <= merged;
      case (state)
        ST_WAIT: begin
          state     <= ST_DATA;
          HREADYOUT <= 1'b1;
        end
        ST_ERR1: begin
          state     <= ST_ERR2;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b1;
        end
        default: begin
          // IDLE, DATA and ERR2 all end with HREADYOUT=1, so a new address phase may be taken.
          state     <= ST_IDLE;
          HRDATA    <= 32'd0;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b0;
          if (accept) begin
            wr_q   <= HWRITE;
            size_q <= HSIZE;
            addr_q <= HADDR[5:0];
            if (illegal) begin
              state     <= ST_ERR1;
              HREADYOUT <= 1'b0;
              HRESP     <= 1'b1;
            end else begin
              state     <= LEGAL_STATE;
              HREADYOUT <= (LEGAL_STATE == ST_DATA);
              if (!HWRITE) HRDATA <= (commit && (widx == ridx)) ? merged : regs[ridx];
            end
          end
        end
      endcase
    end
  end

endmodule
